// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: FSM states,
// parity-type encoding and the expected-parity helper.
package uart_pkg;

    // Widest data word the receiver supports.
    localparam int MAX_WIDTH = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Expected parity bit for a word; unused upper bits must be zero.
    // Even parity is the XOR of the data, odd parity its complement.
    function automatic logic calc_parity(input logic [MAX_WIDTH-1:0] data,
                                         input logic                 par_typ);
        return (par_typ == PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-period timing for the receiver: runs edge_cnt through 0..P-1, captures
// three samples around mid-bit and reports their majority at the last count.
module uart_rx_sampler #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  rx_in,
    output logic                  bit_val,
    output logic                  bit_done
);

    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] edge_cnt_reg;
    logic [PRESCALE_W-1:0] half;
    logic [2:0]            hit;
    logic [2:0]            smp_reg;
    logic [2:0]            smp_eff;

    assign half = prescale >> 1;

    // Sample gi is taken at cnt = P/2-1+gi. When P=4 the last sample lands on
    // the decision count, so the live line value is used in that cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_smp
            logic [PRESCALE_W-1:0] pos;
            assign pos         = half + PRESCALE_W'(gi) - ONE;
            assign hit[gi]     = run && (edge_cnt_reg == pos);
            assign smp_eff[gi] = hit[gi] ? rx_in : smp_reg[gi];
        end
    endgenerate

    assign bit_done = run && (edge_cnt_reg == prescale - ONE);
    assign bit_val  = (smp_eff[0] & smp_eff[1]) |
                      (smp_eff[0] & smp_eff[2]) |
                      (smp_eff[1] & smp_eff[2]);

    // Bit-period counter and sample capture; the counter idles at zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            edge_cnt_reg <= '0;
            smp_reg      <= '0;
        end else begin
            if (!run || bit_done) begin
                edge_cnt_reg <= '0;
            end else begin
                edge_cnt_reg <= edge_cnt_reg + ONE;
            end
            for (int i = 0; i < 3; i++) begin
                if (hit[i]) begin
                    smp_reg[i] <= rx_in;
                end
            end
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: frame FSM, shift register, parity/stop checks
// and a single-word valid/ready output register with error pulses.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  RX_IN,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  overrun
);

    localparam int CNT_W = 4;

    rx_state_t             state_reg, state_next;
    logic                  par_en_reg, par_typ_reg, stop2_reg;
    logic [PRESCALE_W-1:0] prescale_reg;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]      bit_cnt_reg;
    logic                  par_bad_reg;
    logic                  armed_reg;
    logic [DATA_WIDTH-1:0] p_data_reg;
    logic                  data_valid_reg, par_err_reg, stp_err_reg, overrun_reg;

    logic start_det, run, bit_val, bit_done;
    logic last_data, last_stop, frame_end, stop_fail;

    // A start needs the line to have been high since reset, so a line held
    // low through reset does not launch a frame.
    assign start_det = (state_reg == IDLE) && armed_reg && !RX_IN;
    assign run       = start_det || (state_reg == START) || (state_reg == DATA) ||
                       (state_reg == PARITY) || (state_reg == STOP);
    assign last_data = (bit_cnt_reg == CNT_W'(DATA_WIDTH - 1));
    assign last_stop = !stop2_reg || (bit_cnt_reg == CNT_W'(1));

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .prescale (prescale_reg),
        .rx_in    (RX_IN),
        .bit_val  (bit_val),
        .bit_done (bit_done)
    );

    // Next-state logic and frame-end strobes.
    always_comb begin
        state_next = state_reg;
        frame_end  = 1'b0;
        stop_fail  = 1'b0;
        case (state_reg)
            IDLE:       if (start_det) state_next = START;
            START:      if (bit_done) state_next = bit_val ? IDLE : DATA;
            DATA:       if (bit_done && last_data) state_next = par_en_reg ? PARITY : STOP;
            PARITY:     if (bit_done) state_next = STOP;
            STOP: begin
                if (bit_done) begin
                    if (!bit_val) begin
                        state_next = BREAK_WAIT;
                        frame_end  = 1'b1;
                        stop_fail  = 1'b1;
                    end else if (last_stop) begin
                        state_next = IDLE;
                        frame_end  = 1'b1;
                    end
                end
            end
            BREAK_WAIT: if (RX_IN) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // State register, frame datapath and output register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            par_en_reg     <= 1'b0;
            par_typ_reg    <= 1'b0;
            stop2_reg      <= 1'b0;
            prescale_reg   <= '0;
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            par_bad_reg    <= 1'b0;
            armed_reg      <= 1'b0;
            p_data_reg     <= '0;
            data_valid_reg <= 1'b0;
            par_err_reg    <= 1'b0;
            stp_err_reg    <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            par_err_reg <= 1'b0;
            stp_err_reg <= 1'b0;
            overrun_reg <= 1'b0;
            if (RX_IN) begin
                armed_reg <= 1'b1;
            end

            if (start_det) begin
                par_en_reg   <= PAR_EN;
                par_typ_reg  <= PAR_TYP;
                stop2_reg    <= STOP2;
                prescale_reg <= Prescale;
                bit_cnt_reg  <= '0;
                par_bad_reg  <= 1'b0;
            end

            // Data bits arrive LSB first and shift down from the top.
            if (state_reg == DATA && bit_done) begin
                shift_reg   <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
                bit_cnt_reg <= last_data ? '0 : bit_cnt_reg + CNT_W'(1);
            end
            if (state_reg == PARITY && bit_done) begin
                par_bad_reg <= (bit_val != calc_parity(MAX_WIDTH'(shift_reg), par_typ_reg));
            end
            if (state_reg == STOP && bit_done) begin
                bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
            end

            // A handshake and a good frame end on the same edge reload the
            // word without an overrun.
            if (data_valid_reg && data_ready) begin
                data_valid_reg <= 1'b0;
            end
            if (frame_end) begin
                if (stop_fail) begin
                    stp_err_reg <= 1'b1;
                end else if (par_bad_reg) begin
                    par_err_reg <= 1'b1;
                end else if (data_valid_reg && !data_ready) begin
                    overrun_reg <= 1'b1;
                end else begin
                    p_data_reg     <= shift_reg;
                    data_valid_reg <= 1'b1;
                end
            end
        end
    end

    assign P_DATA     = p_data_reg;
    assign data_valid = data_valid_reg;
    assign par_err    = par_err_reg;
    assign stp_err    = stp_err_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed and randomised frames against an outcome model of the receiver;
// an 8-bit and a 7-bit instance share clock, reset and frame configuration.
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       par_en, par_typ, stop2;
    logic [5:0] prescale;
    logic       rx8, rx7, rdy8, rdy7;
    logic [7:0] pd8;
    logic [6:0] pd7;
    logic       dv8, pe8, se8, ov8;
    logic       dv7, pe7, se7, ov7;

    int tests = 0;
    int fails = 0;

    // Model state per instance: index 0 = 8-bit, 1 = 7-bit.
    logic       mv [2];
    logic [8:0] mw [2];

    always #5 clk = ~clk;

    uart_rx_param #(.DATA_WIDTH(8), .PRESCALE_W(6)) u_dut8 (
        .clk(clk), .rst(rst), .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
        .Prescale(prescale), .RX_IN(rx8), .P_DATA(pd8), .data_valid(dv8),
        .data_ready(rdy8), .par_err(pe8), .stp_err(se8), .overrun(ov8)
    );

    uart_rx_param #(.DATA_WIDTH(7), .PRESCALE_W(6)) u_dut7 (
        .clk(clk), .rst(rst), .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
        .Prescale(prescale), .RX_IN(rx7), .P_DATA(pd7), .data_valid(dv7),
        .data_ready(rdy7), .par_err(pe7), .stp_err(se7), .overrun(ov7)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_rx(input bit sel, input logic v);
        if (sel) rx7 = v; else rx8 = v;
    endtask

    task automatic set_rdy(input bit sel, input logic v);
        if (sel) rdy7 = v; else rdy8 = v;
    endtask

    // Hold the line at lvl for n cycles; outputs must stay quiet and match the model.
    task automatic line(input bit sel, input logic lvl, input int n);
        bit bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            drive_rx(sel, lvl);
            @(posedge clk); #1;
            if (sel) begin
                if (pe7 || se7 || ov7 || dv7 !== mv[1] || {2'b0, pd7} !== mw[1]) bad = 1'b1;
            end else begin
                if (pe8 || se8 || ov8 || dv8 !== mv[0] || {1'b0, pd8} !== mw[0]) bad = 1'b1;
            end
        end
        if (n > 0) check("quiet_line", {31'd0, bad}, 32'd0);
    endtask

    task automatic consume(input bit sel);
        set_rdy(sel, 1'b1);
        @(posedge clk); #1;
        set_rdy(sel, 1'b0);
        mv[sel] = 1'b0;
        check("consume_dv", {31'd0, sel ? dv7 : dv8}, 32'd0);
    endtask

    // Drive one frame; bad_stop = 1/2 drives that stop bit low and ends there.
    task automatic send_frame(input bit sel, input logic [8:0] data, input int p,
                              input bit pe_i, input bit pt_i, input bit s2_i,
                              input bit flip, input bit glitch, input int bad_stop,
                              input bit rdy_end);
        int         dw;
        int         nstop;
        int         bstop;
        logic [8:0] d;
        logic       bits[$];
        logic       v;
        logic       dv_before;
        bit         mv_before, exp_se, exp_pe, exp_ov, load;
        dw    = sel ? 7 : 8;
        d     = data & ((9'd1 << dw) - 9'd1);
        nstop = s2_i ? 2 : 1;
        bstop = (bad_stop > nstop) ? nstop : bad_stop;
        par_en = pe_i; par_typ = pt_i; stop2 = s2_i; prescale = 6'(p);
        bits.push_back(1'b0);
        for (int i = 0; i < dw; i++) bits.push_back(d[i]);
        if (pe_i) bits.push_back((^d) ^ pt_i ^ flip);
        for (int k = 1; k <= nstop; k++) begin
            if (k == bstop) begin
                bits.push_back(1'b0);
                break;
            end
            bits.push_back(1'b1);
        end
        mv_before = mv[sel];
        dv_before = 1'b0;
        for (int b = 0; b < bits.size(); b++) begin
            for (int j = 0; j < p; j++) begin
                v = bits[b];
                if (glitch && j == p / 2) v = ~v;
                drive_rx(sel, v);
                if (b == bits.size() - 1 && j == p - 1) begin
                    dv_before = sel ? dv7 : dv8;
                    if (rdy_end) set_rdy(sel, 1'b1);
                end
                @(posedge clk); #1;
                // Configuration must be ignored once the frame has started.
                if (b == 0 && j == 0) begin
                    par_en   = 1'($urandom);
                    par_typ  = 1'($urandom);
                    stop2    = 1'($urandom);
                    prescale = 6'($urandom_range(4, 63));
                end
            end
        end
        set_rdy(sel, 1'b0);
        exp_se = (bstop != 0);
        exp_pe = !exp_se && pe_i && flip;
        exp_ov = !exp_se && !exp_pe && mv_before && !rdy_end;
        load   = !exp_se && !exp_pe && !exp_ov;
        if (load) begin
            mw[sel] = d;
            mv[sel] = 1'b1;
        end else if (mv_before && rdy_end) begin
            mv[sel] = 1'b0;
        end
        check("dv_before_end", {31'd0, dv_before}, {31'd0, mv_before});
        if (sel) begin
            check("stp_err", {31'd0, se7}, {31'd0, exp_se});
            check("par_err", {31'd0, pe7}, {31'd0, exp_pe});
            check("overrun", {31'd0, ov7}, {31'd0, exp_ov});
            check("data_valid", {31'd0, dv7}, {31'd0, mv[1]});
            check("p_data", {25'd0, pd7}, {23'd0, mw[1]});
        end else begin
            check("stp_err", {31'd0, se8}, {31'd0, exp_se});
            check("par_err", {31'd0, pe8}, {31'd0, exp_pe});
            check("overrun", {31'd0, ov8}, {31'd0, exp_ov});
            check("data_valid", {31'd0, dv8}, {31'd0, mv[0]});
            check("p_data", {24'd0, pd8}, {23'd0, mw[0]});
        end
        $display("[TB] frame dut%0d data=%0h P=%0d par=%0d/%0d stop2=%0d flip=%0d bad_stop=%0d rdy_end=%0d -> valid=%0d word=%0h",
                 sel ? 7 : 8, d, p, pe_i, pt_i, s2_i, flip, bstop, rdy_end, mv[sel], mw[sel]);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int  p, gap, bs;
        bit  pe_r, s2_r;
        logic [8:0] dat;
        mv[0] = 1'b0; mv[1] = 1'b0; mw[0] = '0; mw[1] = '0;
        rst = 1'b0; rx8 = 1'b0; rx7 = 1'b0; rdy8 = 1'b0; rdy7 = 1'b0;
        par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; prescale = 6'd8;

        // Reset with the line held low; no frame may start until it idles high.
        repeat (2) @(posedge clk);
        #1;
        check("reset_out8", {19'd0, pd8, dv8, pe8, se8, ov8}, 32'd0);
        check("reset_out7", {20'd0, pd7, dv7, pe7, se7, ov7}, 32'd0);
        rst = 1'b1;
        line(1'b0, 1'b0, 100);
        check("reset_out7_after", {28'd0, dv7, pe7, se7, ov7}, 32'd0);
        rx7 = 1'b1;
        line(1'b0, 1'b1, 3);

        // Basic frame, held until consumed.
        send_frame(1'b0, 9'h45, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        line(1'b0, 1'b1, 10);
        consume(1'b0);

        // Parity: good even-parity frame, then the same frame with the bit flipped.
        send_frame(1'b0, 9'hA8, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        consume(1'b0);
        send_frame(1'b0, 9'hA8, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        line(1'b0, 1'b1, 2);

        // 7-bit odd parity, two stop bits, mid-sample glitch on every bit.
        send_frame(1'b1, 9'h5A, 16, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        line(1'b1, 1'b1, 2);
        consume(1'b1);

        // Short low pulse is rejected as a false start.
        prescale = 6'd16;
        line(1'b0, 1'b0, 3);
        line(1'b0, 1'b1, 30);

        // Framing error, line held low for the rest of 40 clocks, then recovery.
        send_frame(1'b0, 9'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        line(1'b0, 1'b0, 32);
        line(1'b0, 1'b1, 2);
        send_frame(1'b0, 9'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        consume(1'b0);

        // Overrun with back-to-back frames, then same-edge accept.
        send_frame(1'b0, 9'h11, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        send_frame(1'b0, 9'h22, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        consume(1'b0);
        send_frame(1'b0, 9'h11, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        send_frame(1'b0, 9'h22, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        consume(1'b0);

        // Randomised frames on the 8-bit instance.
        bs = 0;
        for (int n = 0; n < 40; n++) begin
            p    = $urandom_range(4, 16);
            dat  = 9'($urandom);
            pe_r = 1'($urandom);
            s2_r = 1'($urandom);
            gap  = (bs != 0) ? $urandom_range(1, 3) : $urandom_range(0, 3);
            line(1'b0, 1'b1, gap);
            if (mv[0] && ($urandom_range(0, 2) == 0)) consume(1'b0);
            bs = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0;
            send_frame(1'b0, dat, p, pe_r, 1'($urandom), s2_r,
                       pe_r && ($urandom_range(0, 5) == 0), 1'($urandom), bs,
                       1'($urandom));
        end
        line(1'b0, 1'b1, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
